// File: rtl/phase_step_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// phase_step_pkg
// Shared types and defaults for the phase-step arbiter slice.
//   state_t  : arbiter FSM states (IDLE, STEP, SETTLE)
//   grant_t  : which requester owns the step in flight
//   DEF_*    : default counter width, limits, reset value and settle interval
//   settle_w : width of the settle down-counter for a given interval
// -----------------------------------------------------------------------------
package phase_step_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;

    localparam int DEF_W          = 4;
    localparam int DEF_MIN_VAL    = 0;
    localparam int DEF_MAX_VAL    = 15;
    localparam int DEF_INIT_VAL   = 0;
    localparam int DEF_SETTLE_CYC = 2;

    // The settle counter holds SETTLE_CYC-1 at most; keep at least one bit so
    // the register exists even when the interval is 0 or 1.
    function automatic int settle_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/phase_step_arbiter_if.sv
// -----------------------------------------------------------------------------
// phase_step_arbiter_if
// Request/ack handshake for two step requesters plus the counter-side outputs.
//   req_a/dir_a, req_b/dir_b : step requests and directions (1=up, 0=down)
//   ack_a/ack_b              : one-cycle acknowledge per requester
//   step_en/up_dnb           : one-cycle step strobe and direction to counter
//   count                    : shadow of the external counter (W bits)
//   sat                      : granted step was blocked at a limit
//   busy                     : arbiter is in STEP or SETTLE
// Modports: master = requester/counter side, slave = arbiter.
// -----------------------------------------------------------------------------
interface phase_step_arbiter_if
    import phase_step_pkg::*;
#(
    parameter int W = DEF_W
);
    logic         req_a;
    logic         dir_a;
    logic         ack_a;
    logic         req_b;
    logic         dir_b;
    logic         ack_b;
    logic         step_en;
    logic         up_dnb;
    logic [W-1:0] count;
    logic         sat;
    logic         busy;

    modport master (
        output req_a, dir_a, req_b, dir_b,
        input  ack_a, ack_b, step_en, up_dnb, count, sat, busy
    );

    modport slave (
        input  req_a, dir_a, req_b, dir_b,
        output ack_a, ack_b, step_en, up_dnb, count, sat, busy
    );

endinterface

// File: rtl/phase_step_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req[1:0] : requests, bit 0 = A, bit 1 = B
//   update   : a grant issued this cycle is taken; advance the pointer
//   gnt[1:0] : one-hot grant (combinational from req and ptr)
//   ptr      : 1 = B wins the next tie, 0 = A wins; resets to favour A
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt,
    output logic       ptr
);

    // NOTE: every variable written in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    // The pointer only moves on a real grant: after granting A, B is favoured.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (update && (gnt != 2'b00)) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/phase_step_arbiter.sv
// -----------------------------------------------------------------------------
// phase_step_arbiter
// Schedules single-LSB up/down steps from two requesters into a shared W-bit
// counter, keeps a saturating shadow of its count and enforces a settle
// interval after every step.
//   clk  : clock, all state updates on posedge
//   rst  : asynchronous active-high reset; aborts a step in flight
//   bus  : phase_step_arbiter_if.slave (requests, acks, step strobe, count,
//          sat, busy)
// Parameters: W, MIN_VAL, MAX_VAL, INIT_VAL, SETTLE_CYC.
// Optional build macro PHASE_STEP_CANCEL_EN: simultaneous opposite-direction
// requests cancel each other in one STEP that acks both and moves nothing.
// All outputs are registered; ack/step_en appear the cycle after STEP.
// -----------------------------------------------------------------------------
module phase_step_arbiter
    import phase_step_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int MIN_VAL    = DEF_MIN_VAL,
    parameter int MAX_VAL    = DEF_MAX_VAL,
    parameter int INIT_VAL   = DEF_INIT_VAL,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                clk,
    input  logic                rst,
    phase_step_arbiter_if.slave bus
);

    localparam int           SW            = settle_w(SETTLE_CYC);
    localparam int           SETTLE_LOAD   = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
    localparam logic [SW-1:0] SETTLE_LOAD_L = SW'(SETTLE_LOAD);
    localparam logic [W-1:0] MIN_L         = W'(MIN_VAL);
    localparam logic [W-1:0] MAX_L         = W'(MAX_VAL);
    localparam logic [W-1:0] INIT_L        = W'(INIT_VAL);

    state_t        state_q, state_d;
    grant_t        gnt_q;
    logic          dir_q;
    logic          cancel_q;
    logic [SW-1:0] settle_q;

    logic [1:0]    req;
    logic [1:0]    arb_gnt;
    logic          rr_ptr;
    logic          arb_upd;
    logic          cancel_now;
    logic          blocked;

    logic          ack_a_q, ack_b_q, step_en_q, up_dnb_q, sat_q, busy_q;
    logic          ack_a_d, ack_b_d, step_en_d, up_dnb_d, sat_d, busy_d;
    logic [W-1:0]  count_q, count_d;

    assign req = {bus.req_b, bus.req_a};

`ifdef PHASE_STEP_CANCEL_EN
    // Opposite-direction tie: the two steps would cancel, so neither moves.
    assign cancel_now = (req == 2'b11) && (bus.dir_a != bus.dir_b);
`else
    assign cancel_now = 1'b0;
`endif

    // A cancelled tie is not a grant, so the pointer stays where it was.
    assign arb_upd = (state_q == IDLE) && !cancel_now;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .update (arb_upd),
        .gnt    (arb_gnt),
        .ptr    (rr_ptr)
    );

    // A tie in IDLE must always resolve toward the requester the pointer names.
    always_comb begin
        if ((state_q == IDLE) && (req == 2'b11) && !cancel_now) begin
            assert (arb_gnt[rr_ptr]);
        end
    end

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req != 2'b00) state_d = STEP;
            STEP:    state_d = (SETTLE_CYC > 0) ? SETTLE : IDLE;
            SETTLE:  if (settle_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Winner and direction are captured at the IDLE decision and used in STEP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q    <= GNT_A;
            dir_q    <= 1'b0;
            cancel_q <= 1'b0;
        end else if ((state_q == IDLE) && (req != 2'b00)) begin
            gnt_q    <= arb_gnt[1] ? GNT_B : GNT_A;
            dir_q    <= arb_gnt[1] ? bus.dir_b : bus.dir_a;
            cancel_q <= cancel_now;
        end
    end

    // Settle down-counter: loaded in STEP, SETTLE exits when it reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q <= '0;
        end else if (state_q == STEP) begin
            settle_q <= SETTLE_LOAD_L;
        end else if ((state_q == SETTLE) && (settle_q != '0)) begin
            settle_q <= settle_q - 1'b1;
        end
    end

    // ---------------------------------------------------------------- FSM: outputs
    // Moving past a limit is refused; count can therefore never wrap.
    assign blocked = dir_q ? (count_q == MAX_L) : (count_q == MIN_L);

    always_comb begin
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        step_en_d = 1'b0;
        up_dnb_d  = 1'b0;
        sat_d     = 1'b0;
        count_d   = count_q;
        busy_d    = (state_d != IDLE);
        if (state_q == STEP) begin
            if (cancel_q) begin
                ack_a_d = 1'b1;
                ack_b_d = 1'b1;
            end else begin
                ack_a_d = (gnt_q == GNT_A);
                ack_b_d = (gnt_q == GNT_B);
                if (blocked) begin
                    sat_d = 1'b1;
                end else begin
                    step_en_d = 1'b1;
                    up_dnb_d  = dir_q;
                    count_d   = dir_q ? count_q + 1'b1 : count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            step_en_q <= 1'b0;
            up_dnb_q  <= 1'b0;
            sat_q     <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= INIT_L;
        end else begin
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            step_en_q <= step_en_d;
            up_dnb_q  <= up_dnb_d;
            sat_q     <= sat_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
        end
    end

    assign bus.ack_a   = ack_a_q;
    assign bus.ack_b   = ack_b_q;
    assign bus.step_en = step_en_q;
    assign bus.up_dnb  = up_dnb_q;
    assign bus.sat     = sat_q;
    assign bus.busy    = busy_q;
    assign bus.count   = count_q;

endmodule

// File: tb/tb_phase_step_arbiter.sv
// -----------------------------------------------------------------------------
// tb_phase_step_arbiter
// Scoreboard bench for phase_step_arbiter. Two instances: dut (SETTLE_CYC=2)
// and dut0 (SETTLE_CYC=0), both W=4, limits 0..15, INIT_VAL=0. Expected acks
// are queued when requests are raised and popped when an ack appears.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_phase_step_arbiter;
    import phase_step_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    phase_step_arbiter_if #(.W(W)) bus  ();
    phase_step_arbiter_if #(.W(W)) bus0 ();

    phase_step_arbiter #(
        .W(W), .MIN_VAL(0), .MAX_VAL(15), .INIT_VAL(0), .SETTLE_CYC(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    phase_step_arbiter #(
        .W(W), .MIN_VAL(0), .MAX_VAL(15), .INIT_VAL(0), .SETTLE_CYC(0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    typedef struct {
        logic         ack_a;
        logic         ack_b;
        logic         step_en;
        logic         up_dnb;
        logic         sat;
        logic [W-1:0] count;
        int           cyc;     // expected cycle relative to request; -1 = any
    } exp_t;

    typedef struct {
        logic         ack_a;
        logic         ack_b;
        logic         step_en;
        logic         up_dnb;
        logic         sat;
        logic         busy;
        logic [W-1:0] count;
    } obs_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   edge_n      = 0;
    int   base        = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic a, input logic b, input logic en,
                            input logic up, input logic s, input int cnt,
                            input int cyc);
        exp_t e;
        e.ack_a = a; e.ack_b = b; e.step_en = en; e.up_dnb = up; e.sat = s;
        e.count = W'(cnt);
        e.cyc   = cyc;
        sb.push_back(e);
    endtask

    task automatic sample(input bit which, output obs_t o);
        if (which) begin
            o.ack_a = bus0.ack_a; o.ack_b = bus0.ack_b; o.step_en = bus0.step_en;
            o.up_dnb = bus0.up_dnb; o.sat = bus0.sat; o.busy = bus0.busy;
            o.count = bus0.count;
        end else begin
            o.ack_a = bus.ack_a; o.ack_b = bus.ack_b; o.step_en = bus.step_en;
            o.up_dnb = bus.up_dnb; o.sat = bus.sat; o.busy = bus.busy;
            o.count = bus.count;
        end
    endtask

    // Pop the oldest expectation and compare it with an observed ack cycle.
    task automatic score(input obs_t o, input string tag);
        exp_t e;
        int   rel;
        rel = edge_n - base;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s unexpected ack: ack_a=%b ack_b=%b count=%0d at cycle %0d",
                     tag, o.ack_a, o.ack_b, o.count, rel);
            return;
        end
        e = sb.pop_front();
        if ({o.ack_a, o.ack_b, o.step_en, o.sat} !== {e.ack_a, e.ack_b, e.step_en, e.sat}) begin
            miscompares++;
            $display("FAIL %s {ack_a,ack_b,step_en,sat} got %b%b%b%b want %b%b%b%b",
                     tag, o.ack_a, o.ack_b, o.step_en, o.sat,
                     e.ack_a, e.ack_b, e.step_en, e.sat);
        end
        vectors++;
        if (o.count !== e.count) begin
            miscompares++;
            $display("FAIL %s count got %0d want %0d", tag, o.count, e.count);
        end
        if (e.step_en) begin
            vectors++;
            if (o.up_dnb !== e.up_dnb) begin
                miscompares++;
                $display("FAIL %s up_dnb got %b want %b", tag, o.up_dnb, e.up_dnb);
            end
        end
        if (e.cyc >= 0) begin
            vectors++;
            if (rel != e.cyc) begin
                miscompares++;
                $display("FAIL %s ack cycle got %0d want %0d", tag, rel, e.cyc);
            end
        end
    endtask

    // Wait (bounded) for n ack events on the chosen instance and score each.
    task automatic drain(input bit which, input int n, input string tag);
        obs_t o;
        bit   seen;
        for (int k = 0; k < n; k++) begin
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                sample(which, o);
                if (o.ack_a || o.ack_b) seen = 1'b1;
            end
            if (!seen) begin
                vectors++;
                miscompares++;
                $display("FAIL %s timeout waiting for ack %0d of %0d", tag, k + 1, n);
                sb.delete();
                return;
            end
            score(o, tag);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_a = 1'b0;  bus.dir_a = 1'b0;  bus.req_b = 1'b0;  bus.dir_b = 1'b0;
        bus0.req_a = 1'b0; bus0.dir_a = 1'b0; bus0.req_b = 1'b0; bus0.dir_b = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t o;
        do_reset();
        for (int w = 0; w < 2; w++) begin
            sample(w[0], o);
            vectors++;
            if ({o.ack_a, o.ack_b, o.step_en, o.up_dnb, o.sat, o.busy} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset outputs inst%0d got %b want 000000", w,
                         {o.ack_a, o.ack_b, o.step_en, o.up_dnb, o.sat, o.busy});
            end
            vectors++;
            if (o.count !== 4'd0) begin
                miscompares++;
                $display("FAIL reset count inst%0d got %0d want 0", w, o.count);
            end
        end
    endtask

    // Held up-request from A: steps at cycles 1, 5, 9, then nothing.
    task automatic test_single_stream();
        obs_t o;
        int   extra;
        do_reset();
        bus.dir_a = 1'b1;
        bus.req_a = 1'b1;
        base = edge_n + 1;
        for (int i = 1; i <= 3; i++) push_exp(1, 0, 1, 1, 0, i, 1 + 4 * (i - 1));
        drain(0, 3, "single");
        bus.req_a = 1'b0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            sample(0, o);
            if (o.ack_a || o.ack_b || o.step_en) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL single idle acks got %0d want 0", extra);
        end
        vectors++;
        if (o.count !== 4'd3) begin
            miscompares++;
            $display("FAIL single final count got %0d want 3", o.count);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.dir_a = 1'b1; bus.dir_b = 1'b1;
        bus.req_a = 1'b1; bus.req_b = 1'b1;
        base = edge_n + 1;
        for (int i = 1; i <= 4; i++) begin
            if (i % 2 == 1) push_exp(1, 0, 1, 1, 0, i, 1 + 4 * (i - 1));
            else            push_exp(0, 1, 1, 1, 0, i, 1 + 4 * (i - 1));
        end
        drain(0, 4, "rr");
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_saturation();
        obs_t o;
        do_reset();
        bus.dir_a = 1'b1;
        bus.req_a = 1'b1;
        base = edge_n + 1;
        for (int i = 1; i <= 15; i++) push_exp(1, 0, 1, 1, 0, i, -1);
        push_exp(1, 0, 0, 1, 1, 15, -1);
        drain(0, 16, "sat_hi");
        bus.req_a = 1'b0;
        @(negedge clk);
        sample(0, o);
        vectors++;
        if ({o.sat, o.count} !== {1'b0, 4'd15}) begin
            miscompares++;
            $display("FAIL sat_hi after pulse {sat,count} got %b/%0d want 0/15", o.sat, o.count);
        end
        repeat (4) @(negedge clk);
        bus.dir_a = 1'b0;
        bus.req_a = 1'b1;
        base = edge_n + 1;
        for (int i = 14; i >= 0; i--) push_exp(1, 0, 1, 0, 0, i, -1);
        push_exp(1, 0, 0, 0, 1, 0, 1 + 4 * 15);
        drain(0, 16, "sat_lo");
        bus.req_a = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        obs_t o;
        do_reset();
        bus.dir_a = 1'b1;
        bus.req_a = 1'b1;
        base = edge_n + 1;
        for (int i = 1; i <= 7; i++) push_exp(1, 0, 1, 1, 0, i, -1);
        drain(0, 7, "mid");
        // Now in SETTLE at count 7: reset lands asynchronously.
        bus.req_a = 1'b0;
        rst = 1'b1;
        #1;
        sample(0, o);
        vectors++;
        if ({o.ack_a, o.ack_b, o.step_en, o.up_dnb, o.sat, o.busy} !== 6'b0) begin
            miscompares++;
            $display("FAIL mid_reset outputs got %b want 000000",
                     {o.ack_a, o.ack_b, o.step_en, o.up_dnb, o.sat, o.busy});
        end
        vectors++;
        if (o.count !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_reset count got %0d want 0", o.count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.dir_a = 1'b1;
        bus.req_a = 1'b1;
        base = edge_n + 1;
        push_exp(1, 0, 1, 1, 0, 1, 1);
        drain(0, 1, "post_reset");
        bus.req_a = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // SETTLE_CYC=0 instance: busy high in even cycles, ack in odd cycles.
    task automatic test_settle_zero();
        obs_t o;
        int   rel;
        do_reset();
        bus0.dir_b = 1'b1;
        bus0.req_b = 1'b1;
        base = edge_n + 1;
        for (int i = 1; i <= 4; i++) push_exp(0, 1, 1, 1, 0, i, 2 * i - 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            sample(1, o);
            rel = edge_n - base;
            vectors++;
            if (o.busy !== ((rel % 2) == 0)) begin
                miscompares++;
                $display("FAIL settle0 busy at cycle %0d got %b want %b", rel, o.busy, (rel % 2) == 0);
            end
            if (o.ack_a || o.ack_b) score(o, "settle0");
        end
        bus0.req_b = 1'b0;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL settle0 missing acks got %0d pending want 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_cancel();
        do_reset();
        // Five steps via B leave count 5 and the pointer favouring A.
        bus.dir_b = 1'b1;
        bus.req_b = 1'b1;
        base = edge_n + 1;
        for (int i = 1; i <= 5; i++) push_exp(0, 1, 1, 1, 0, i, -1);
        drain(0, 5, "cancel_setup");
        bus.req_b = 1'b0;
        repeat (4) @(negedge clk);
        bus.dir_a = 1'b1; bus.dir_b = 1'b0;
        bus.req_a = 1'b1; bus.req_b = 1'b1;
        base = edge_n + 1;
`ifdef PHASE_STEP_CANCEL_EN
        push_exp(1, 1, 0, 0, 0, 5, 1);
`else
        push_exp(1, 0, 1, 1, 0, 6, 1);
`endif
        drain(0, 1, "cancel_tie");
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        repeat (4) @(negedge clk);
        // Same-direction tie: shows whether the pointer moved on the tie above.
        bus.dir_a = 1'b1; bus.dir_b = 1'b1;
        bus.req_a = 1'b1; bus.req_b = 1'b1;
        base = edge_n + 1;
`ifdef PHASE_STEP_CANCEL_EN
        push_exp(1, 0, 1, 1, 0, 6, 1);
`else
        push_exp(0, 1, 1, 1, 0, 7, 1);
`endif
        drain(0, 1, "cancel_follow");
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_saturation();
        test_reset_mid();
        test_settle_zero();
        test_cancel();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/phase_step_arbiter.md
Name: phase_step_arbiter

Overview:
- Schedules single-LSB up/down steps into a shared W-bit up/down counter, such as the phase-step counter in the phasestep bench.
- Two requesters (A, B) each ask for one step in a given direction; the block arbitrates them round-robin.
- Issues step_en/up_dnb to the counter and keeps a shadow of its count, saturating at programmable limits.
- Enforces a settle interval between steps to model loop latency.

Parameters:
W, 4, counter width in bits
MIN_VAL, 0, lowest legal count
MAX_VAL, 15, highest legal count (2^W-1 max)
INIT_VAL, 0, count after reset; MIN_VAL <= INIT_VAL <= MAX_VAL
SETTLE_CYC, 2, idle cycles enforced after each STEP; 0 allowed

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
req_a  input  1  requester A step request, held high until ack_a
dir_a  input  1  A direction, 1=up 0=down; stable while req_a high
ack_a  output  1  one-cycle ack to A
req_b  input  1  requester B step request
dir_b  input  1  B direction
ack_b  output  1  one-cycle ack to B
step_en  output  1  one-cycle enable to counter
up_dnb  output  1  direction to counter, valid when step_en=1
count  output  W  shadow count, mirrors counter after each step
sat  output  1  one-cycle pulse: granted step blocked at limit
busy  output  1  high in STEP and SETTLE

Behaviour:
- All outputs registered.
- Reset values: count=INIT_VAL; ack_a=ack_b=step_en=up_dnb=sat=busy=0; state=IDLE; rr pointer favours A.
- Reset asserted mid-operation aborts the step in flight. No ack is issued for it; the requester re-requests.
- FSM states: IDLE, STEP, SETTLE.
- IDLE:
  - Any req high at posedge: latch grant and direction, go to STEP.
  - Tie: grant the requester not granted last. Pointer flips only on an actual grant.
- STEP (exactly one cycle):
  - Winner's ack=1.
  - If a move is legal: step_en=1, up_dnb=dir, count +/-1.
  - Up at count==MAX_VAL or down at count==MIN_VAL: step_en=0, count holds, sat=1, ack still issued.
  - Next state: SETTLE if SETTLE_CYC>0, else IDLE.
- SETTLE:
  - Lasts SETTLE_CYC cycles, counted by a down-counter, then IDLE.
  - Requests ignored, never lost; req stays high per protocol.
- Latency: req rising at IDLE posedge N gives ack/step_en visible after posedge N+1.
- Throughput: one step per 2+SETTLE_CYC cycles.
- Handshake:
  - Requester deasserts req the cycle after ack, or keeps it high to request the next step.
  - A req high for two consecutive cycles after ack counts as a new request.
  - Losing requester keeps req high; it is served next, guaranteed within one arbitration round.
- No wrap-around: count never leaves [MIN_VAL, MAX_VAL]. No arithmetic overflow is possible.

Optional Feature:
- Macro: PHASE_STEP_CANCEL_EN.
- Defined:
  - In IDLE, req_a and req_b both high with opposite dirs: one STEP cycle acks both, step_en=0, sat=0, count holds, rr pointer unchanged.
  - Then SETTLE as usual.
  - Same-direction ties arbitrate normally.
- Undefined: all ties arbitrate round-robin regardless of direction.

Decomposition:
- Package phase_step_pkg:
  - state enum typedef (IDLE, STEP, SETTLE)
  - grant typedef (GNT_A, GNT_B)
  - default width/limit constants
- Sub-module rr_arb2: two-input round-robin arbiter. Inputs: req pair, update strobe. Outputs: one-hot grant, pointer register.
- Settle down-counter stays inline.

Test Plan:
1. Reset with INIT_VAL=0; req_a=1, dir_a=1 for 3 requests, SETTLE_CYC=2 -> step_en pulses at cycles 1, 5, 9; count 1, 2, 3; ack_a aligned with step_en.
2. req_a and req_b high together, both up, held -> acks alternate A, B, A, B; count increments each STEP.
3. count=15, up request -> sat=1, step_en=0, ack issued, count stays 15. At count=0, down request -> sat, count stays 0.
4. rst asserted during SETTLE at count=7 -> outputs immediately at reset values, count=INIT_VAL; next request proceeds normally.
5. SETTLE_CYC=0, req_b held high -> step every 2 cycles; busy toggles 1/0.
6. PHASE_STEP_CANCEL_EN defined, req_a up and req_b down same cycle at count=5 -> ack_a=ack_b=1, step_en=0, count=5. With the macro undefined -> A granted, count=6.
